booth_product_accumulator: RTL and testbench

- Downstream consumer of the pipelined Booth multiplier.
- Takes the multiplier's one-cycle Valid/Product pulses, sums a configurable number of consecutive signed products per group, and presents each group sum on a valid/ready output.
- The multiplier cannot be stalled, so this block accepts a product every cycle unconditionally. The only back-pressure point is the single-entry result register.

---
 rtl/booth_product_accumulator_pkg.sv | 21 ++
 rtl/booth_acc_out_reg.sv | 55 +++++
 rtl/booth_product_accumulator.sv | 114 +++++++++++
 tb/tb_booth_product_accumulator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_product_accumulator_pkg.sv
// Shared widths and FSM encoding for the Booth product accumulator.
package booth_product_accumulator_pkg;

    localparam int PN_DEF        = 4;
    localparam int ACC_GUARD_DEF = 8;
    localparam int LEN_W_DEF     = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;

    function automatic int prod_width(input int pn);
        return 2 ** (pn + 1);
    endfunction

    function automatic int acc_width(input int pn, input int guard);
        return prod_width(pn) + guard;
    endfunction

endpackage

// File: rtl/booth_acc_out_reg.sv
// Single-entry valid/ready result register; a completion that finds it
// occupied and not being drained is dropped and flagged as overrun.
module booth_acc_out_reg #(
    parameter int AW = 40,
    parameter int CW = 9
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [AW-1:0] i_sum,
    input  logic [CW-1:0] i_count,
    input  logic          i_ovf,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [AW-1:0] o_sum,
    output logic [CW-1:0] o_count,
    output logic          o_ovf,
    output logic          o_overrun
);

    logic          r_valid;
    logic [AW-1:0] r_sum;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_overrun;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid   <= 1'b0;
            r_sum     <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_load) begin
            // a handshake in the same cycle frees the slot for the new result
            if (!r_valid || i_ready) begin
                r_valid <= 1'b1;
                r_sum   <= i_sum;
                r_count <= i_count;
                r_ovf   <= i_ovf;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_sum     = r_sum;
    assign o_count   = r_count;
    assign o_ovf     = r_ovf;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums groups of consecutive signed products from the multiplier and
// presents each group total through a single-entry valid/ready register.
module booth_product_accumulator
    import booth_product_accumulator_pkg::*;
#(
    parameter int pN        = PN_DEF,
    parameter int ACC_GUARD = ACC_GUARD_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    localparam int PW       = prod_width(pN),
    localparam int AW       = acc_width(pN, ACC_GUARD)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Valid,
    input  logic [PW-1:0]    In_Product,
    input  logic [LEN_W-1:0] Cfg_Len,
    input  logic             Flush,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [AW-1:0]    Out_Sum,
    output logic [LEN_W:0]   Out_Count,
    output logic             Out_Ovf,
    output logic             Overrun
);

    acc_state_t     r_state, w_state_next;
    logic [AW-1:0]  r_acc;
    logic [LEN_W:0] r_cnt;
    logic [LEN_W:0] r_len;
    logic           r_ovf;

    logic [AW-1:0]  w_prod_ext;
    logic [AW-1:0]  w_addend;
    logic [AW-1:0]  w_acc_sum;
    logic [LEN_W:0] w_len_cfg;
    logic           w_ovf_step;
    logic [AW-1:0]  w_acc_next;
    logic [LEN_W:0] w_cnt_next;
    logic           w_ovf_next;
    logic           w_complete;

    assign w_prod_ext = {{ACC_GUARD{In_Product[PW-1]}}, In_Product};
    assign w_addend   = In_Valid ? w_prod_ext : '0;
    assign w_acc_sum  = r_acc + w_addend;
    // a length of zero encodes the full 2**LEN_W group
    assign w_len_cfg  = (Cfg_Len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, Cfg_Len};
    assign w_ovf_step = In_Valid && (r_acc[AW-1] == w_prod_ext[AW-1])
                        && (w_acc_sum[AW-1] != r_acc[AW-1]);

    always_ff @(posedge Clk) begin
        if (Rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_ovf_next   = r_ovf;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_acc_next = w_prod_ext;
                w_cnt_next = {{LEN_W{1'b0}}, In_Valid};
                w_ovf_next = 1'b0;
                w_complete = In_Valid && ((w_len_cfg == {{LEN_W{1'b0}}, 1'b1}) || Flush);
                if (In_Valid && !w_complete) w_state_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                w_acc_next = w_acc_sum;
                w_cnt_next = r_cnt + {{LEN_W{1'b0}}, In_Valid};
                w_ovf_next = r_ovf || w_ovf_step;
                w_complete = Flush || (In_Valid && (w_cnt_next == r_len));
                if (w_complete) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (In_Valid) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
            end
            if (r_state == ST_IDLE && In_Valid) r_len <= w_len_cfg;
            r_ovf <= w_ovf_next;
        end
    end

    booth_acc_out_reg #(
        .AW (AW),
        .CW (LEN_W + 1)
    ) u_out_reg (
        .i_clk     (Clk),
        .i_rst     (Rst),
        .i_load    (w_complete),
        .i_sum     (w_acc_next),
        .i_count   (w_cnt_next),
        .i_ovf     (w_ovf_next),
        .i_ready   (Out_Ready),
        .o_valid   (Out_Valid),
        .o_sum     (Out_Sum),
        .o_count   (Out_Count),
        .o_ovf     (Out_Ovf),
        .o_overrun (Overrun)
    );

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: vector table plus hand sequences,
// with expected group results queued at drive time and popped on handshake.
module tb_booth_product_accumulator;

    typedef struct {
        logic [39:0] sum;
        logic [8:0]  cnt;
        logic        ovf;
        int          due;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] p;
        logic [7:0]  len;
        logic        fl;
        logic        done;
        logic [39:0] sum;
        logic [8:0]  cnt;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic        in_valid, flush, out_ready;
    logic [31:0] in_product;
    logic [7:0]  cfg_len;
    logic        o_valid0, o_ovf0, overrun0;
    logic [39:0] o_sum0;
    logic [8:0]  o_cnt0;

    logic        in_valid1, flush1, out_ready1;
    logic [31:0] in_product1;
    logic [7:0]  cfg_len1;
    logic        o_valid1, o_ovf1, overrun1;
    logic [32:0] o_sum1;
    logic [8:0]  o_cnt1;

    exp_t q0[$];
    exp_t q1[$];
    vec_t tbl[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_product_accumulator u_dut0 (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Product(in_product),
        .Cfg_Len(cfg_len), .Flush(flush), .Out_Valid(o_valid0), .Out_Ready(out_ready),
        .Out_Sum(o_sum0), .Out_Count(o_cnt0), .Out_Ovf(o_ovf0), .Overrun(overrun0)
    );

    booth_product_accumulator #(.ACC_GUARD(1)) u_dut1 (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid1), .In_Product(in_product1),
        .Cfg_Len(cfg_len1), .Flush(flush1), .Out_Valid(o_valid1), .Out_Ready(out_ready1),
        .Out_Sum(o_sum1), .Out_Count(o_cnt1), .Out_Ovf(o_ovf1), .Overrun(overrun1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] p, input logic [7:0] len,
                                input logic fl, input logic done, input logic [39:0] sum,
                                input logic [8:0] cnt, input logic ovf);
        vec_t r;
        r.v = v; r.p = p; r.len = len; r.fl = fl;
        r.done = done; r.sum = sum; r.cnt = cnt; r.ovf = ovf;
        return r;
    endfunction

    task automatic push0(input logic [39:0] sum, input logic [8:0] cnt, input logic ovf, input int due);
        exp_t e;
        e.sum = sum; e.cnt = cnt; e.ovf = ovf; e.due = due;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [39:0] sum, input logic [8:0] cnt, input logic ovf, input int due);
        exp_t e;
        e.sum = sum; e.cnt = cnt; e.ovf = ovf; e.due = due;
        q1.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("dut0_sum", o_sum0, e.sum);
                check("dut0_count", o_cnt0, e.cnt);
                check("dut0_ovf", o_ovf0, e.ovf);
                if (e.due >= 0) check("dut0_latency", cyc, e.due);
            end
        end
        if (!rst && o_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_sum", {7'b0, o_sum1}, e.sum);
                check("dut1_count", o_cnt1, e.cnt);
                check("dut1_ovf", o_ovf1, e.ovf);
                if (e.due >= 0) check("dut1_latency", cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 0; in_product = 0; cfg_len = 0; flush = 0; out_ready = 1;
        in_valid1 = 0; in_product1 = 0; cfg_len1 = 0; flush1 = 0; out_ready1 = 1;
        repeat (2) step();
        check("rst_valid", o_valid0, 0);
        check("rst_sum", o_sum0, 0);
        check("rst_count", o_cnt0, 0);
        check("rst_ovf", o_ovf0, 0);
        check("rst_overrun", overrun0, 0);
        check("rst_valid1", o_valid1, 0);
        rst = 1'b0;
        step();

        tbl.push_back(mk(1, 32'd3,         8'd4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'd5,         8'd4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'hFFFFFFFE,  8'd4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'd10,        8'd4, 0, 1, 40'd16, 9'd4, 0));
        tbl.push_back(mk(1, 32'hFFFFFFFF,  8'd1, 0, 1, 40'hFF_FFFF_FFFF, 9'd1, 0));
        tbl.push_back(mk(1, 32'hFFFFFFFF,  8'd1, 0, 1, 40'hFF_FFFF_FFFF, 9'd1, 0));
        tbl.push_back(mk(1, 32'd7,         8'd1, 0, 1, 40'd7, 9'd1, 0));
        tbl.push_back(mk(0, 32'd0,         8'd1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'd1,         8'd8, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'd2,         8'd8, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'd3,         8'd8, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'd0,         8'd8, 1, 1, 40'd6, 9'd3, 0));
        tbl.push_back(mk(0, 32'd0,         8'd8, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'd0,         8'd8, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'd5,         8'd3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'd6,         8'd1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'd7,         8'd1, 0, 1, 40'd18, 9'd3, 0));
        tbl.push_back(mk(1, 32'hFFFFFFFB,  8'd2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'hFFFFFFF9,  8'd2, 0, 1, 40'hFF_FFFF_FFF4, 9'd2, 0));
        tbl.push_back(mk(1, 32'd9,         8'd4, 1, 1, 40'd9, 9'd1, 0));
        tbl.push_back(mk(1, 32'd1,         8'd4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'd2,         8'd4, 1, 1, 40'd3, 9'd2, 0));

        foreach (tbl[i]) begin
            in_valid = tbl[i].v; in_product = tbl[i].p;
            cfg_len = tbl[i].len; flush = tbl[i].fl;
            if (tbl[i].done) push0(tbl[i].sum, tbl[i].cnt, tbl[i].ovf, cyc + 1);
            step();
        end
        in_valid = 0; flush = 0;
        repeat (3) step();

        // back-pressure: first result held, second dropped
        out_ready = 0; cfg_len = 8'd2;
        in_valid = 1; in_product = 32'd1; step();
        push0(40'd2, 9'd2, 0, -1);
        step();
        in_product = 32'd7; step();
        step();
        in_valid = 0;
        check("bp_valid", o_valid0, 1);
        check("bp_sum_held", o_sum0, 40'd2);
        check("bp_count_held", o_cnt0, 9'd2);
        check("bp_overrun", overrun0, 1);
        step();
        check("bp_sum_stable", o_sum0, 40'd2);
        out_ready = 1;
        step();
        check("bp_valid_drop", o_valid0, 0);
        check("bp_overrun_sticky", overrun0, 1);
        step();

        // partial group discarded by reset
        cfg_len = 8'd4; in_valid = 1; in_product = 32'd8;
        step(); step();
        in_valid = 0; rst = 1;
        step();
        check("mid_rst_valid", o_valid0, 0);
        check("mid_rst_sum", o_sum0, 0);
        check("mid_rst_count", o_cnt0, 0);
        check("mid_rst_overrun", overrun0, 0);
        rst = 0;
        in_valid = 1; in_product = 32'd4;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) push0(40'd16, 9'd4, 0, cyc + 1);
            step();
        end
        in_valid = 0;

        // narrow accumulator wrap with overflow flag, then a clean group
        cfg_len1 = 8'd3; in_valid1 = 1; in_product1 = 32'h7FFFFFFF;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) push1(40'h1_7FFF_FFFD, 9'd3, 1, cyc + 1);
            step();
        end
        cfg_len1 = 8'd1; in_product1 = 32'd1;
        push1(40'd1, 9'd1, 0, cyc + 1);
        step();
        in_valid1 = 0;

        for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) step();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("end_overrun1", overrun1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
